hack_mem_bridge: RTL and testbench

Memory-request bridge between `hack_cpu` and `ram_manager`'s SDRAM request buffer. It samples each CPU memory access on a one-cycle `cpu_tick` strobe and maps the 15-bit Hack address into the 20-bit SDRAM space. It pushes exactly one request per access into the buffer with a single-cycle write-request pulse. For reads, it stalls the CPU clock divider until read data returns or a timeout expires. It replaces the free-running push toggle in the top level.

---
 rtl/hack_mem_pkg.sv | 24 ++
 rtl/hack_mem_bridge.sv | 106 ++++++++++
 tb/tb_hack_mem_bridge.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// Shared types and widths for the Hack CPU to SDRAM request bridge.
package hack_mem_pkg;

   localparam int HACK_ADDR_W        = 15;
   localparam int SDRAM_ADDR_W       = 20;
   localparam int WORD_W             = 16;
   localparam int TMO_CNT_W          = 16;
   localparam int RD_TIMEOUT_DEFAULT = 1024;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PUSH    = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   // Zero-extend the CPU address and offset it; the sum wraps at 20 bits.
   function automatic logic [SDRAM_ADDR_W-1:0] map_addr(
      input logic [SDRAM_ADDR_W-1:0] base,
      input logic [HACK_ADDR_W-1:0]  addr
   );
      return base + {{(SDRAM_ADDR_W-HACK_ADDR_W){1'b0}}, addr};
   endfunction

endpackage

// File: rtl/hack_mem_bridge.sv
// Samples one CPU access per cpu_tick, pushes one SDRAM request (wrreq at T+2 unless buf_full holds it),
// and stalls the CPU until the push is done and, for reads, until data or timeout.
module hack_mem_bridge
   import hack_mem_pkg::*;
#(
   parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                      TIMEOUT   = RD_TIMEOUT_DEFAULT
) (
   input  logic                    clk50,
   input  logic                    reset,
   input  logic                    cpu_tick,
   input  logic [HACK_ADDR_W-1:0]  cpu_addr,
   input  logic [WORD_W-1:0]       cpu_wdata,
   input  logic                    cpu_we,
   input  logic                    cpu_re,
   output logic [WORD_W-1:0]       cpu_rdata,
   output logic                    cpu_stall,
   output logic [SDRAM_ADDR_W-1:0] buf_addr,
   output logic [WORD_W-1:0]       buf_data,
   output logic                    buf_rw,
   output logic                    buf_wrreq,
   input  logic                    buf_full,
   input  logic                    rd_valid,
   input  logic [WORD_W-1:0]       rd_data,
   output logic                    err_timeout,
   output logic                    err_overrun
);

   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

   state_t                  state;
   logic [HACK_ADDR_W-1:0]  req_addr;
   logic [WORD_W-1:0]       req_data;
   logic                    req_we;
   logic [TMO_CNT_W-1:0]    tmo_cnt;

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         req_addr    <= '0;
         req_data    <= '0;
         req_we      <= 1'b0;
         tmo_cnt     <= '0;
         cpu_rdata   <= '0;
         cpu_stall   <= 1'b0;
         buf_addr    <= '0;
         buf_data    <= '0;
         buf_rw      <= 1'b0;
         buf_wrreq   <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         buf_wrreq <= 1'b0;
         if (cpu_tick && state != ST_IDLE) begin
            err_overrun <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (cpu_tick && (cpu_we || cpu_re)) begin
                  req_addr  <= cpu_addr;
                  req_data  <= cpu_wdata;
                  req_we    <= cpu_we;
                  cpu_stall <= 1'b1;
                  state     <= ST_PUSH;
               end
            end
            ST_PUSH: begin
               // The pulse cycle itself is spent in PUSH so the stall covers it.
               if (buf_wrreq) begin
                  if (req_we) begin
                     cpu_stall <= 1'b0;
                     state     <= ST_IDLE;
                  end else begin
                     tmo_cnt <= '0;
                     state   <= ST_WAIT_RD;
                  end
               end else if (!buf_full) begin
                  buf_wrreq <= 1'b1;
                  buf_addr  <= map_addr(BASE_ADDR, req_addr);
                  buf_data  <= req_data;
                  buf_rw    <= req_we;
               end
            end
            ST_WAIT_RD: begin
               if (rd_valid) begin
                  cpu_rdata <= rd_data;
                  cpu_stall <= 1'b0;
                  state     <= ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  cpu_rdata   <= '0;
                  err_timeout <= 1'b1;
                  cpu_stall   <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               cpu_stall <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hack_mem_bridge.sv
// Three bridges (different base/timeout) share one stimulus stream; a timestamp-based model predicts every output.
module tb_hack_mem_bridge;

   localparam int ND = 3;

   function automatic logic [19:0] base_of(input int d);
      return (d == 0) ? 20'h00000 : (d == 1) ? 20'h08000 : 20'hFFFF0;
   endfunction

   function automatic int tmo_of(input int d);
      return (d == 0) ? 1024 : 8;
   endfunction

   logic        clk50 = 1'b0;
   logic        reset;
   logic        cpu_tick;
   logic [14:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_we;
   logic        cpu_re;
   logic        buf_full;
   logic        rd_valid;
   logic [15:0] rd_data;

   logic [15:0] rdata_o [ND];
   logic        stall_o [ND];
   logic [19:0] addr_o  [ND];
   logic [15:0] data_o  [ND];
   logic        rw_o    [ND];
   logic        wrreq_o [ND];
   logic        to_o    [ND];
   logic        ovr_o   [ND];

   always #5 clk50 = ~clk50;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      hack_mem_bridge #(.BASE_ADDR(base_of(g)), .TIMEOUT(tmo_of(g))) u_dut (
         .clk50      (clk50),
         .reset      (reset),
         .cpu_tick   (cpu_tick),
         .cpu_addr   (cpu_addr),
         .cpu_wdata  (cpu_wdata),
         .cpu_we     (cpu_we),
         .cpu_re     (cpu_re),
         .cpu_rdata  (rdata_o[g]),
         .cpu_stall  (stall_o[g]),
         .buf_addr   (addr_o[g]),
         .buf_data   (data_o[g]),
         .buf_rw     (rw_o[g]),
         .buf_wrreq  (wrreq_o[g]),
         .buf_full   (buf_full),
         .rd_valid   (rd_valid),
         .rd_data    (rd_data),
         .err_timeout(to_o[g]),
         .err_overrun(ovr_o[g])
      );
   end

   int errors = 0;
   int checks = 0;
   int unsigned kcyc = 0;

   // Reference: an access is an outstanding job with an acceptance and a push timestamp.
   logic        m_busy   [ND];
   logic        m_pushed [ND];
   logic        m_we     [ND];
   logic [14:0] m_addr   [ND];
   logic [15:0] m_data   [ND];
   int unsigned m_push   [ND];
   logic [15:0] e_rdata  [ND];
   logic        e_stall  [ND];
   logic [19:0] e_addr   [ND];
   logic [15:0] e_data   [ND];
   logic        e_rw     [ND];
   logic        e_wrreq  [ND];
   logic        e_to     [ND];
   logic        e_ovr    [ND];

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_busy[d] = 0; m_pushed[d] = 0; m_we[d] = 0; m_addr[d] = '0; m_data[d] = '0; m_push[d] = 0;
         e_rdata[d] = '0; e_stall[d] = 0; e_addr[d] = '0; e_data[d] = '0;
         e_rw[d] = 0; e_wrreq[d] = 0; e_to[d] = 0; e_ovr[d] = 0;
      end
   endtask

   // Applies the inputs of cycle kcyc; the results are the outputs expected in cycle kcyc+1.
   task automatic model_edge();
      for (int d = 0; d < ND; d++) begin
         e_wrreq[d] = 0;
         if (reset) begin
            m_busy[d] = 0; m_pushed[d] = 0;
            e_rdata[d] = '0; e_addr[d] = '0; e_data[d] = '0; e_rw[d] = 0;
            e_to[d] = 0; e_ovr[d] = 0;
         end else if (m_busy[d]) begin
            if (cpu_tick) e_ovr[d] = 1;
            if (!m_pushed[d]) begin
               if (!buf_full) begin
                  m_pushed[d] = 1;
                  m_push[d]   = kcyc + 1;
                  e_wrreq[d]  = 1;
                  e_addr[d]   = 20'(base_of(d) + {5'b0, m_addr[d]});
                  e_data[d]   = m_data[d];
                  e_rw[d]     = m_we[d];
               end
            end else if (m_we[d]) begin
               if (kcyc == m_push[d]) m_busy[d] = 0;
            end else if (kcyc > m_push[d]) begin
               if (rd_valid) begin
                  e_rdata[d] = rd_data;
                  m_busy[d]  = 0;
               end else if (kcyc == m_push[d] + tmo_of(d)) begin
                  e_rdata[d] = '0;
                  e_to[d]    = 1;
                  m_busy[d]  = 0;
               end
            end
         end else if (cpu_tick && (cpu_we || cpu_re)) begin
            m_busy[d]   = 1;
            m_pushed[d] = 0;
            m_we[d]     = cpu_we;
            m_addr[d]   = cpu_addr;
            m_data[d]   = cpu_wdata;
         end
         e_stall[d] = m_busy[d];
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("d%0d_rdata@%0d", d, kcyc), 32'(rdata_o[d]), 32'(e_rdata[d]));
         chk($sformatf("d%0d_stall@%0d", d, kcyc), 32'(stall_o[d]), 32'(e_stall[d]));
         chk($sformatf("d%0d_addr@%0d", d, kcyc), 32'(addr_o[d]), 32'(e_addr[d]));
         chk($sformatf("d%0d_data@%0d", d, kcyc), 32'(data_o[d]), 32'(e_data[d]));
         chk($sformatf("d%0d_rw@%0d", d, kcyc), 32'(rw_o[d]), 32'(e_rw[d]));
         chk($sformatf("d%0d_wrreq@%0d", d, kcyc), 32'(wrreq_o[d]), 32'(e_wrreq[d]));
         chk($sformatf("d%0d_tmo@%0d", d, kcyc), 32'(to_o[d]), 32'(e_to[d]));
         chk($sformatf("d%0d_ovr@%0d", d, kcyc), 32'(ovr_o[d]), 32'(e_ovr[d]));
      end
   endtask

   task automatic step();
      @(posedge clk50);
      model_edge();
      kcyc++;
      @(negedge clk50);
      check_all();
   endtask

   task automatic quiet();
      cpu_tick = 0; cpu_we = 0; cpu_re = 0; rd_valid = 0; buf_full = 0;
   endtask

   task automatic access(input logic [14:0] a, input logic [15:0] w, input logic we, input logic re);
      cpu_tick = 1; cpu_addr = a; cpu_wdata = w; cpu_we = we; cpu_re = re;
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("%s_d%0d", tag, d),
             {rdata_o[d], 4'(addr_o[d] != 0), 4'(data_o[d] != 0), 2'b0, stall_o[d], rw_o[d], wrreq_o[d], to_o[d], ovr_o[d], 1'b0},
             32'h0);
      end
   endtask

   int pulses;

   initial begin
      reset = 1; cpu_addr = '0; cpu_wdata = '0; rd_data = '0;
      quiet();
      model_reset();
      #1;
      chk_reset_vals("reset_state");
      step(); step();
      reset = 0;

      // Write, no backpressure
      access(15'h0010, 16'hBEEF, 1, 0);
      step(); quiet();
      chk("wr_stall_t1", 32'(stall_o[0]), 32'd1);
      chk("wr_wrreq_t1", 32'(wrreq_o[0]), 32'd0);
      step();
      chk("wr_wrreq_t2", 32'(wrreq_o[0]), 32'd1);
      chk("wr_addr_t2", 32'(addr_o[0]), 32'h00010);
      chk("wr_rw_t2", 32'(rw_o[0]), 32'd1);
      chk("wr_data_t2", 32'(data_o[0]), 32'hBEEF);
      chk("wr_stall_t2", 32'(stall_o[0]), 32'd1);
      step();
      chk("wr_stall_t3", 32'(stall_o[0]), 32'd0);
      chk("wr_wrreq_t3", 32'(wrreq_o[0]), 32'd0);

      // Read round trip, data five cycles after the push
      access(15'h7FFF, 16'h0000, 0, 1);
      step(); quiet();
      step();
      chk("rd_wrreq", 32'(wrreq_o[1]), 32'd1);
      chk("rd_addr_base", 32'(addr_o[1]), 32'h0FFFF);
      chk("rd_rw", 32'(rw_o[1]), 32'd0);
      repeat (5) step();
      chk("rd_stall_wait", 32'(stall_o[1]), 32'd1);
      rd_valid = 1; rd_data = 16'h1234;
      step(); quiet();
      chk("rd_rdata", 32'(rdata_o[1]), 32'h1234);
      chk("rd_stall_low", 32'(stall_o[1]), 32'd0);

      // Backpressure: buffer full for ten cycles after the tick
      access(15'h0042, 16'h5555, 1, 0);
      step(); quiet();
      buf_full = 1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         pulses += int'(wrreq_o[0]);
         chk($sformatf("bp_stall_%0d", i), 32'(stall_o[0]), 32'd1);
      end
      chk("bp_no_push_while_full", 32'(pulses), 32'd0);
      buf_full = 0;
      step();
      chk("bp_push_after_drop", 32'(wrreq_o[0]), 32'd1);
      step();
      chk("bp_single_pulse", 32'(wrreq_o[0]), 32'd0);
      chk("bp_stall_low", 32'(stall_o[0]), 32'd0);

      // Timeout (instances 1 and 2 use TIMEOUT 8)
      access(15'h0100, 16'h0000, 0, 1);
      step(); quiet();
      step();
      repeat (8) step();
      chk("tmo_stall_last_wait", 32'(stall_o[1]), 32'd1);
      chk("tmo_flag_not_yet", 32'(to_o[1]), 32'd0);
      step();
      chk("tmo_stall_low", 32'(stall_o[1]), 32'd0);
      chk("tmo_flag", 32'(to_o[1]), 32'd1);
      chk("tmo_rdata_zero", 32'(rdata_o[1]), 32'h0);
      chk("tmo_long_still_waits", 32'(stall_o[0]), 32'd1);
      step();
      rd_valid = 1; rd_data = 16'hAAAA;
      step(); quiet();
      chk("tmo_late_data_ignored", 32'(rdata_o[1]), 32'h0);
      chk("tmo_long_gets_data", 32'(rdata_o[0]), 32'hAAAA);

      // Overrun: tick during WAIT_RD is dropped
      access(15'h0123, 16'h0000, 0, 1);
      step(); quiet();
      step(); step();
      access(15'h0456, 16'h7777, 1, 0);
      step(); quiet();
      chk("ovr_flag", 32'(ovr_o[1]), 32'd1);
      pulses = 0;
      rd_valid = 1; rd_data = 16'h0F0F;
      step(); quiet();
      pulses += int'(wrreq_o[1]);
      for (int i = 0; i < 4; i++) begin
         step();
         pulses += int'(wrreq_o[1]);
      end
      chk("ovr_no_extra_push", 32'(pulses), 32'd0);
      chk("ovr_rdata", 32'(rdata_o[1]), 32'h0F0F);

      // Address wrap past 20'hFFFFF
      access(15'h0020, 16'h1111, 1, 0);
      step(); quiet();
      step();
      chk("wrap_addr", 32'(addr_o[2]), 32'h00010);
      chk("wrap_addr_mid", 32'(addr_o[1]), 32'h08020);
      step();

      // Reset mid-read, then a normal read
      access(15'h0033, 16'h0000, 0, 1);
      step(); quiet();
      step(); step();
      #2 reset = 1;
      #1;
      model_reset();
      chk_reset_vals("reset_mid_read");
      step();
      reset = 0;
      access(15'h0055, 16'h0000, 0, 1);
      step(); quiet();
      step();
      chk("post_reset_push", 32'(wrreq_o[0]), 32'd1);
      chk("post_reset_addr", 32'(addr_o[0]), 32'h00055);
      step();
      rd_valid = 1; rd_data = 16'h5A5A;
      step(); quiet();
      chk("post_reset_rdata", 32'(rdata_o[0]), 32'h5A5A);
      chk("post_reset_stall", 32'(stall_o[0]), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         cpu_tick  = ($urandom_range(0, 4) == 0);
         cpu_addr  = 15'($urandom);
         cpu_wdata = 16'($urandom);
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_re    = 1'($urandom_range(0, 1));
         buf_full  = ($urandom_range(0, 2) == 0);
         rd_valid  = ($urandom_range(0, 5) == 0);
         rd_data   = 16'($urandom);
         reset     = (i == 400);
         step();
      end
      reset = 0;
      quiet();
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
